// File: rtl/poly_eval_sqcbrt_if.sv
// Host and cube-root handshake bundle for poly_eval_sqcbrt.
// Handshake: start is sampled only when the block is idle. cbrt_start and cbrt_ready, like ready, are one-cycle pulses, and data travels in the same cycle as its pulse.
interface poly_eval_sqcbrt_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cbrt_start;
    logic [WIDTH-1:0] cbrt_x;
    logic [WIDTH-1:0] cbrt_y;
    logic             cbrt_ready;
    logic [WIDTH-1:0] y;
    logic             ready;
    logic             busy;

    modport master (
        output start, a, b, cbrt_y, cbrt_ready,
        input  cbrt_start, cbrt_x, y, ready, busy
    );

    modport slave (
        input  start, a, b, cbrt_y, cbrt_ready,
        output cbrt_start, cbrt_x, y, ready, busy
    );
endinterface

// File: rtl/poly_eval_sqcbrt.sv
// y = a^2 + cbrt(b): the square is formed by a serial shift-add multiplier while the external cube-root unit runs.
// Optional POLY_SAT_EN: the square and the sum clamp to 2^WIDTH-1 instead of wrapping.
module poly_eval_sqcbrt #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    poly_eval_sqcbrt_if.slave    bus,
    output logic [1:0]           dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SUM  = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
`ifdef POLY_SAT_EN
    // The multiplicand keeps its shifted-out bits so that lost partial products still register as overflow.
    localparam int MW = 2 * WIDTH;
    localparam int AW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
    localparam int AW = WIDTH;
`endif

    state_t           state;
    logic [MW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [AW-1:0]    acc;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] root;
    logic             root_vld;

    logic [AW-1:0]    acc_add;
    logic [WIDTH-1:0] square;
    logic [WIDTH-1:0] sum_out;
    logic [WIDTH-1:0] root_sel;
    logic             square_done;

    assign dbg_state   = state;
    assign square_done = (counter == WIDTH_C);
    assign root_sel    = root_vld ? root : bus.cbrt_y;

`ifdef POLY_SAT_EN
    logic [WIDTH:0] add_lo;
    logic [WIDTH:0] sum_full;

    // Bit WIDTH of acc is a sticky overflow flag.
    assign add_lo   = {1'b0, acc[WIDTH-1:0]} + {1'b0, mcand[WIDTH-1:0]};
    assign acc_add  = {acc[WIDTH] | add_lo[WIDTH] | (|mcand[MW-1:WIDTH]), add_lo[WIDTH-1:0]};
    assign square   = acc[WIDTH] ? {WIDTH{1'b1}} : acc[WIDTH-1:0];
    assign sum_full = {1'b0, square} + {1'b0, root};
    assign sum_out  = sum_full[WIDTH] ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
    assign acc_add  = acc + mcand;
    assign square   = acc;
    assign sum_out  = square + root;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            mcand          <= '0;
            mplier         <= '0;
            acc            <= '0;
            counter        <= '0;
            root           <= '0;
            root_vld       <= 1'b0;
            bus.cbrt_start <= 1'b0;
            bus.cbrt_x     <= '0;
            bus.y          <= '0;
            bus.ready      <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.ready      <= 1'b0;
            bus.cbrt_start <= 1'b0;
            case (state)
                IDLE: begin
                    // busy stays up through the ready cycle and falls on the next idle cycle.
                    bus.busy <= bus.start;
                    if (bus.start) begin
                        mcand          <= MW'(bus.a);
                        mplier         <= bus.a;
                        bus.cbrt_x     <= bus.b;
                        acc            <= '0;
                        counter        <= '0;
                        root_vld       <= 1'b0;
                        bus.cbrt_start <= 1'b1;
                        state          <= CALC;
                    end
                end
                CALC: begin
                    bus.busy <= 1'b1;
                    if (counter < WIDTH_C) begin
                        if (mplier[0]) begin
                            acc <= acc_add;
                        end
                        mcand   <= mcand << 1;
                        mplier  <= mplier >> 1;
                        counter <= counter + 1'b1;
                    end
                    if (bus.cbrt_ready && !root_vld) begin
                        root     <= bus.cbrt_y;
                        root_vld <= 1'b1;
                    end
                    // A root arriving in the finishing cycle is taken straight from cbrt_y.
                    if (square_done && (root_vld || bus.cbrt_ready)) begin
                        root  <= root_sel;
                        state <= SUM;
                    end
                end
                SUM: begin
                    bus.busy  <= 1'b1;
                    bus.y     <= sum_out;
                    bus.ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_poly_eval_sqcbrt.sv
// Self-checking bench for poly_eval_sqcbrt with a behavioural cube-root unit of programmable latency.
module tb_poly_eval_sqcbrt;
    localparam int W = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    logic [1:0] idle_code;
    int         tests_run = 0;
    int         tests_failed = 0;
    logic [W-1:0] exp_q[$];

    poly_eval_sqcbrt_if #(.WIDTH(W)) bus();

    poly_eval_sqcbrt #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic int icbrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic logic [W-1:0] ref_y(input int av, input int bv);
        longint sq;
        longint s;
        sq = longint'(av) * longint'(av);
`ifdef POLY_SAT_EN
        if (sq > 65535) sq = 65535;
        s = sq + icbrt(bv);
        if (s > 65535) s = 65535;
`else
        s = (sq + icbrt(bv)) % 65536;
`endif
        return W'(s);
    endfunction

    function automatic int exp_edge(input int l);
        return ((l > W) ? l : W) + 2;
    endfunction

    // ---------------- cube-root unit model ----------------
    int           model_lat = 1;
    bit           model_dbl = 1'b0;
    bit           model_mute = 1'b0;
    int           cb_cnt = -100;
    logic         cb_ready = 1'b0;
    logic         stray_ready = 1'b0;
    logic [W-1:0] cb_y_v = '0;
    logic [W-1:0] pending_x = '0;

    assign bus.cbrt_ready = cb_ready | stray_ready;
    assign bus.cbrt_y     = cb_y_v;

    always @(negedge clk) begin
        if (bus.cbrt_start) begin
            cb_cnt    = model_lat;
            pending_x = bus.cbrt_x;
            cb_ready  = 1'b0;
            cb_y_v    = W'($urandom);
        end else begin
            cb_cnt--;
            if (cb_cnt == 0 && !model_mute) begin
                cb_ready = 1'b1;
                cb_y_v   = W'(icbrt(int'(pending_x)));
            end else if (cb_cnt == -2 && model_dbl) begin
                cb_ready = 1'b1;
                cb_y_v   = ~W'(icbrt(int'(pending_x)));
            end else begin
                cb_ready = 1'b0;
                cb_y_v   = W'($urandom);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int lat,
                          input int mid_edge, output logic [W-1:0] yv, output int rdy_edge,
                          output int pulses, output int cs_pulses, output logic [W-1:0] cx,
                          output int busy_bad);
        model_lat = lat;
        yv = '0; rdy_edge = -1; pulses = 0; cs_pulses = 0; busy_bad = 0; cx = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = av; bus.b = bv;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom);
        if (bus.cbrt_start) cs_pulses++;
        cx = bus.cbrt_x;
        if (!bus.busy) busy_bad++;
        for (int e = 1; e <= 200; e++) begin
            if (e == mid_edge) begin
                bus.start = 1'b1; bus.a = W'(9); bus.b = W'(1000);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.cbrt_start) cs_pulses++;
            if (bus.ready) begin
                pulses++;
                if (rdy_edge < 0) begin
                    rdy_edge = e;
                    yv = bus.y;
                end
            end
            if (rdy_edge < 0 || e == rdy_edge) begin
                if (!bus.busy) busy_bad++;
            end else if (e == rdy_edge + 1) begin
                if (bus.busy) busy_bad++;
            end
            if (rdy_edge >= 0 && e >= rdy_edge + 3) break;
        end
        bus.start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_code = dbg_state;
        tests_run++;
        if (bus.y !== '0 || bus.ready !== 1'b0 || bus.busy !== 1'b0 ||
            bus.cbrt_start !== 1'b0 || bus.cbrt_x !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: y=%0d ready=%b busy=%b cbrt_start=%b cbrt_x=%0d, required all zero",
                     bus.y, bus.ready, bus.busy, bus.cbrt_start, bus.cbrt_x);
        end
    endtask

    task automatic check_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input int lat, input int mid_edge);
        logic [W-1:0] yv;
        logic [W-1:0] cx;
        int rdy, pulses, cs, busy_bad;
        logic [W-1:0] exp_y;
        exp_y = ref_y(int'(av), int'(bv));
        run_op(av, bv, lat, mid_edge, yv, rdy, pulses, cs, cx, busy_bad);
        tests_run++;
        if (yv !== exp_y) begin
            tests_failed++;
            $display("FAIL %s y: got %0d, required %0d", name, yv, exp_y);
        end
        tests_run++;
        if (rdy !== exp_edge(lat)) begin
            tests_failed++;
            $display("FAIL %s ready_edge: got %0d, required %0d", name, rdy, exp_edge(lat));
        end
        tests_run++;
        if (pulses !== 1 || cs !== 1) begin
            tests_failed++;
            $display("FAIL %s pulse_counts: ready=%0d cbrt_start=%0d, required 1 and 1", name, pulses, cs);
        end
        tests_run++;
        if (cx !== bv || busy_bad !== 0) begin
            tests_failed++;
            $display("FAIL %s cbrt_x/busy: cbrt_x=%0d busy_errors=%0d, required %0d and 0", name, cx, busy_bad, bv);
        end
    endtask

    task automatic test_plan_cases();
        check_op("a3_b27_l30", 16'd3, 16'd27, 30, -1);
        check_op("a0_b0_l1", 16'd0, 16'd0, 1, -1);
        check_op("a255_b64_l16", 16'd255, 16'd64, 16, -1);
    endtask

    task automatic test_square_wrap();
        check_op("a256_b8", 16'd256, 16'd8, 4, -1);
        check_op("a65535_b65535", 16'hFFFF, 16'hFFFF, 20, -1);
    endtask

    task automatic test_start_while_busy();
        check_op("start_mid_calc", 16'd5, 16'd125, 8, 5);
    endtask

    task automatic test_random();
        logic [W-1:0] yv;
        logic [W-1:0] cx;
        logic [W-1:0] av, bv, exp_y;
        int rdy, pulses, cs, busy_bad, lat;
        for (int i = 0; i < 12; i++) begin
            av = W'($urandom_range(0, 65535));
            bv = W'($urandom_range(0, 65535));
            lat = $urandom_range(1, 40);
            model_dbl = ($urandom_range(0, 1) == 1);
            exp_q.push_back(ref_y(int'(av), int'(bv)));
            run_op(av, bv, lat, -1, yv, rdy, pulses, cs, cx, busy_bad);
            exp_y = exp_q.pop_front();
            tests_run++;
            if (yv !== exp_y || rdy !== exp_edge(lat) || pulses !== 1) begin
                tests_failed++;
                $display("FAIL random_%0d: a=%0d b=%0d L=%0d y=%0d edge=%0d pulses=%0d, required y=%0d edge=%0d pulses=1",
                         i, av, bv, lat, yv, rdy, pulses, exp_y, exp_edge(lat));
            end
        end
        model_dbl = 1'b0;
    endtask

    task automatic test_no_root();
        int ready_seen = 0;
        int busy_low = 0;
        model_mute = 1'b1;
        model_lat = 3;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'd7; bus.b = 16'd8;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (60) begin
            @(posedge clk); #1;
            if (bus.ready) ready_seen++;
            if (!bus.busy) busy_low++;
        end
        tests_run++;
        if (ready_seen !== 0 || busy_low !== 0 || dbg_state === idle_code) begin
            tests_failed++;
            $display("FAIL no_root_stall: ready_pulses=%0d busy_low_cycles=%0d state_idle=%b, required 0 0 0",
                     ready_seen, busy_low, dbg_state === idle_code);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_mute = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || dbg_state !== idle_code) begin
            tests_failed++;
            $display("FAIL no_root_reset: busy=%b, required 0 and idle state", bus.busy);
        end
    endtask

    task automatic test_rst_mid_calc();
        int bad = 0;
        model_lat = 10;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'd100; bus.b = 16'd900;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++;
        if (bus.y !== '0 || bus.ready !== 1'b0 || bus.busy !== 1'b0 ||
            bus.cbrt_start !== 1'b0 || bus.cbrt_x !== '0 || dbg_state !== idle_code) begin
            tests_failed++;
            $display("FAIL rst_mid_calc: y=%0d ready=%b busy=%b cbrt_start=%b cbrt_x=%0d, required all zero",
                     bus.y, bus.ready, bus.busy, bus.cbrt_start, bus.cbrt_x);
        end
        // The model's pending root lands around edge 11, while the block is idle.
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.ready || bus.busy || bus.y !== '0) bad++;
        end
        stray_ready = 1'b1;
        @(posedge clk); #1;
        stray_ready = 1'b0;
        @(posedge clk); #1;
        if (bus.ready || bus.busy || bus.y !== '0) bad++;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL stray_root_idle: disturbed cycles=%0d, required 0", bad);
        end
        check_op("after_rst_a2_b1", 16'd2, 16'd1, 3, -1);
    endtask

    task automatic test_back_to_back();
        int edges[$];
        logic [W-1:0] ys[$];
        logic [W-1:0] y1, y2;
        y1 = ref_y(1234, 4096);
        y2 = ref_y(77, 27000);
        model_lat = 5;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'd1234; bus.b = 16'd4096;
        @(posedge clk); #1;
        bus.a = 16'd77; bus.b = 16'd27000;
        for (int e = 1; e <= 45; e++) begin
            @(posedge clk); #1;
            if (bus.ready) begin
                edges.push_back(e);
                ys.push_back(bus.y);
                if (edges.size() == 2) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        tests_run++;
        if (edges.size() !== 2) begin
            tests_failed++;
            $display("FAIL back_to_back_count: got %0d ready pulses, required 2", edges.size());
        end else begin
            tests_run++;
            if (edges[0] !== 18 || edges[1] !== 37 || ys[0] !== y1 || ys[1] !== y2) begin
                tests_failed++;
                $display("FAIL back_to_back: edges %0d,%0d y %0d,%0d, required edges 18,37 y %0d,%0d",
                         edges[0], edges[1], ys[0], ys[1], y1, y2);
            end
        end
        repeat (25) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        idle_code = '0;
        test_reset();
        test_plan_cases();
        test_square_wrap();
        test_start_while_busy();
        test_random();
        test_no_root();
        test_rst_mid_calc();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
